// File: rtl/cpu65_pkg.sv
// Shared types and constants for the cpu65 datapath: bus select codes, vector FSM
// states, interrupt vector bases and control-word bit positions.
package cpu65_pkg;

    typedef enum logic [3:0] {
        BUS_Y     = 4'h0,
        BUS_X     = 4'h1,
        BUS_SP    = 4'h2,
        BUS_ALU   = 4'h3,
        BUS_A     = 4'h4,
        BUS_PCL   = 4'h5,
        BUS_PCH   = 4'h6,
        BUS_IDL   = 4'h7,
        BUS_DBUFF = 4'h8,
        BUS_PSR   = 4'h9,
        BUS_BZ    = 4'hA
    } bus_sel_e;

    typedef enum logic [1:0] {
        VEC_IDLE = 2'd0,
        VEC_LO   = 2'd1,
        VEC_HI   = 2'd2
    } vec_state_e;

    localparam logic [15:0] VEC_RES = 16'hFFFC;
    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    localparam int IDC_INC_PC    = 9;
    localparam int IDC_INC_A     = 8;
    localparam int IDC_DEC_A     = 7;
    localparam int IDC_INC_X     = 6;
    localparam int IDC_DEC_X     = 5;
    localparam int IDC_INC_Y     = 4;
    localparam int IDC_DEC_Y     = 3;
    localparam int IDC_INC_SP    = 2;
    localparam int IDC_DEC_SP    = 1;
    localparam int IDC_CLEAR_IDL = 0;

    localparam int VO_PUSH_VECTOR = 4;
    localparam int VO_PUSH_RESB   = 3;
    localparam int VO_PUSH_NMIB   = 2;
    localparam int VO_PUSH_IRQB   = 1;
    localparam int VO_RESET_STACK = 0;

    // Simultaneous inc and dec cancel out; the conflict itself is flagged elsewhere.
    function automatic logic [7:0] step_byte(input logic [7:0] value,
                                             input logic       inc,
                                             input logic       dec);
        logic [7:0] result;
        if (inc && !dec) begin
            result = value + 8'd1;
        end else if (dec && !inc) begin
            result = value - 8'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

    function automatic logic is_undef_code(input logic [3:0] code);
        return (code > 4'hA);
    endfunction

endpackage

// File: rtl/rtu_vector_fsm.sv
// Reset/NMI/IRQ vector fetch sequencer: latches the vector base, collects the low
// byte and hands a complete 16-bit target to the register file.
module rtu_vector_fsm
    import cpu65_pkg::*;
(
    input  logic        fclk,
    input  logic        reset,
    input  logic        rdy,
    input  logic        push_vector,
    input  logic        push_resb,
    input  logic        push_nmib,
    input  logic        push_irqb,
    input  logic [7:0]  data_in,
    output logic        vec_busy,
    output logic [15:0] vec_addr,
    output logic        pc_load,
    output logic [15:0] pc_value,
    output logic        vec_err
);

    vec_state_e  state_r;
    logic [7:0]  temp_r;
    logic [15:0] vec_addr_r;
    logic        busy_r;
    logic        one_hot_s;
    logic [15:0] base_s;

    // Decode the vector select and flag malformed or overlapping requests.
    always_comb begin
        one_hot_s = 1'b1;
        base_s    = VEC_RES;
        case ({push_resb, push_nmib, push_irqb})
            3'b100:  base_s = VEC_RES;
            3'b010:  base_s = VEC_NMI;
            3'b001:  base_s = VEC_IRQ;
            default: one_hot_s = 1'b0;
        endcase
        if (push_vector) begin
            vec_err = (state_r != VEC_IDLE) || !one_hot_s;
        end else begin
            vec_err = 1'b0;
        end
    end

    // Sequencer state, fetched low byte and presented vector address.
    always_ff @(posedge fclk) begin
        if (reset) begin
            state_r    <= VEC_IDLE;
            temp_r     <= 8'h00;
            vec_addr_r <= 16'h0000;
            busy_r     <= 1'b0;
        end else if (rdy) begin
            case (state_r)
                VEC_IDLE: begin
                    if (push_vector && one_hot_s) begin
                        state_r    <= VEC_LO;
                        vec_addr_r <= base_s;
                        busy_r     <= 1'b1;
                    end
                end
                VEC_LO: begin
                    temp_r     <= data_in;
                    state_r    <= VEC_HI;
                    vec_addr_r <= vec_addr_r + 16'd1;
                end
                VEC_HI: begin
                    state_r    <= VEC_IDLE;
                    vec_addr_r <= 16'h0000;
                    busy_r     <= 1'b0;
                end
                default: begin
                    state_r    <= VEC_IDLE;
                    vec_addr_r <= 16'h0000;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign vec_busy = busy_r;
    assign vec_addr = vec_addr_r;
    assign pc_load  = rdy && (state_r == VEC_HI);
    assign pc_value = {data_in, temp_r};

endmodule

// File: rtl/register_transfer_unit.sv
// Register file and internal bus for the cpu65 datapath. Optional build macro
// RTU_UNDEF_TRAP_EN makes bus codes B-F raise xfer_err instead of acting as BZ.
module register_transfer_unit
    import cpu65_pkg::*;
#(
    parameter logic [7:0] PSR_RESET = 8'h34,
    parameter logic [7:0] SP_RESET  = 8'hFF
) (
    input  logic        fclk,
    input  logic        reset,
    input  logic        rdy,
    input  logic [3:0]  read,
    input  logic [3:0]  write,
    input  logic        adb_to_pc,
    input  logic [9:0]  inc_dec_clr,
    input  logic [4:0]  vector_ops,
    input  logic [7:0]  alu_result,
    input  logic [7:0]  data_in,
    input  logic        load_dl,
    input  logic [7:0]  adl_in,
    input  logic [7:0]  adh_in,
    output logic [7:0]  reg_a,
    output logic [7:0]  reg_x,
    output logic [7:0]  reg_y,
    output logic [7:0]  reg_sp,
    output logic [7:0]  reg_pcl,
    output logic [7:0]  reg_pch,
    output logic [7:0]  reg_idl,
    output logic [7:0]  reg_dbuff,
    output logic [7:0]  reg_psr,
    output logic [7:0]  int_bus,
    output logic        vec_busy,
    output logic [15:0] vec_addr,
    output logic        xfer_err
);

    logic [7:0]  a_r, x_r, y_r, sp_r, pcl_r, pch_r, idl_r, dbuff_r, psr_r;
    logic        xfer_err_r;
    logic [7:0]  int_bus_s;
    logic        vec_busy_s, vec_load_s, vec_err_s;
    logic [15:0] vec_pc_s, pc_inc_s;
    logic        bus_wr_ok_s, inc_pc_en_s, adb_en_s;
    logic        wr_y_s, wr_x_s, wr_sp_s, wr_a_s, wr_pcl_s, wr_pch_s;
    logic        wr_idl_s, wr_dbuff_s, wr_psr_s;
    logic        conflict_s, undef_err_s;

    rtu_vector_fsm u_vector_fsm (
        .fclk        (fclk),
        .reset       (reset),
        .rdy         (rdy),
        .push_vector (vector_ops[VO_PUSH_VECTOR]),
        .push_resb   (vector_ops[VO_PUSH_RESB]),
        .push_nmib   (vector_ops[VO_PUSH_NMIB]),
        .push_irqb   (vector_ops[VO_PUSH_IRQB]),
        .data_in     (data_in),
        .vec_busy    (vec_busy_s),
        .vec_addr    (vec_addr),
        .pc_load     (vec_load_s),
        .pc_value    (vec_pc_s),
        .vec_err     (vec_err_s)
    );

    // Internal bus source mux; BZ and every unassigned code drive zero.
    always_comb begin
        int_bus_s = 8'h00;
        case (read)
            BUS_Y:     int_bus_s = y_r;
            BUS_X:     int_bus_s = x_r;
            BUS_SP:    int_bus_s = sp_r;
            BUS_ALU:   int_bus_s = alu_result;
            BUS_A:     int_bus_s = a_r;
            BUS_PCL:   int_bus_s = pcl_r;
            BUS_PCH:   int_bus_s = pch_r;
            BUS_IDL:   int_bus_s = idl_r;
            BUS_DBUFF: int_bus_s = dbuff_r;
            BUS_PSR:   int_bus_s = psr_r;
            default:   int_bus_s = 8'h00;
        endcase
    end

    assign bus_wr_ok_s = !vec_busy_s;
    assign inc_pc_en_s = inc_dec_clr[IDC_INC_PC] && !vec_busy_s;
    assign adb_en_s    = adb_to_pc && !vec_busy_s;
    assign pc_inc_s    = {pch_r, pcl_r} + 16'd1;

    // Destination decode; ALU as a destination has no storage and is a no-op.
    always_comb begin
        wr_y_s     = 1'b0;
        wr_x_s     = 1'b0;
        wr_sp_s    = 1'b0;
        wr_a_s     = 1'b0;
        wr_pcl_s   = 1'b0;
        wr_pch_s   = 1'b0;
        wr_idl_s   = 1'b0;
        wr_dbuff_s = 1'b0;
        wr_psr_s   = 1'b0;
        if (bus_wr_ok_s) begin
            case (write)
                BUS_Y:     wr_y_s     = 1'b1;
                BUS_X:     wr_x_s     = 1'b1;
                BUS_SP:    wr_sp_s    = 1'b1;
                BUS_A:     wr_a_s     = 1'b1;
                BUS_PCL:   wr_pcl_s   = 1'b1;
                BUS_PCH:   wr_pch_s   = 1'b1;
                BUS_IDL:   wr_idl_s   = 1'b1;
                BUS_DBUFF: wr_dbuff_s = 1'b1;
                BUS_PSR:   wr_psr_s   = 1'b1;
                default:   wr_y_s     = 1'b0;
            endcase
        end else begin
            wr_y_s = 1'b0;
        end
    end

    assign conflict_s = (inc_dec_clr[IDC_INC_A]  && inc_dec_clr[IDC_DEC_A])  ||
                        (inc_dec_clr[IDC_INC_X]  && inc_dec_clr[IDC_DEC_X])  ||
                        (inc_dec_clr[IDC_INC_Y]  && inc_dec_clr[IDC_DEC_Y])  ||
                        (inc_dec_clr[IDC_INC_SP] && inc_dec_clr[IDC_DEC_SP]);

`ifdef RTU_UNDEF_TRAP_EN
    assign undef_err_s = is_undef_code(read) || is_undef_code(write);
`else
    assign undef_err_s = 1'b0;
`endif

    // Register file: vector load > adb_to_pc > bus write > load_dl > inc/dec/clear.
    always_ff @(posedge fclk) begin
        if (reset) begin
            a_r        <= 8'h00;
            x_r        <= 8'h00;
            y_r        <= 8'h00;
            sp_r       <= SP_RESET;
            pcl_r      <= 8'h00;
            pch_r      <= 8'h00;
            idl_r      <= 8'h00;
            dbuff_r    <= 8'h00;
            psr_r      <= PSR_RESET;
            xfer_err_r <= 1'b0;
        end else if (rdy) begin
            a_r <= wr_a_s ? int_bus_s
                          : step_byte(a_r, inc_dec_clr[IDC_INC_A], inc_dec_clr[IDC_DEC_A]);
            x_r <= wr_x_s ? int_bus_s
                          : step_byte(x_r, inc_dec_clr[IDC_INC_X], inc_dec_clr[IDC_DEC_X]);
            y_r <= wr_y_s ? int_bus_s
                          : step_byte(y_r, inc_dec_clr[IDC_INC_Y], inc_dec_clr[IDC_DEC_Y]);

            if (vector_ops[VO_RESET_STACK]) begin
                sp_r <= SP_RESET;
            end else if (wr_sp_s) begin
                sp_r <= int_bus_s;
            end else begin
                sp_r <= step_byte(sp_r, inc_dec_clr[IDC_INC_SP], inc_dec_clr[IDC_DEC_SP]);
            end

            // PC bytes resolve priority independently once no full-word load applies.
            if (vec_load_s) begin
                pcl_r <= vec_pc_s[7:0];
                pch_r <= vec_pc_s[15:8];
            end else if (adb_en_s) begin
                pcl_r <= adl_in;
                pch_r <= adh_in;
            end else begin
                if (wr_pcl_s) begin
                    pcl_r <= int_bus_s;
                end else if (inc_pc_en_s) begin
                    pcl_r <= pc_inc_s[7:0];
                end else begin
                    pcl_r <= pcl_r;
                end
                if (wr_pch_s) begin
                    pch_r <= int_bus_s;
                end else if (inc_pc_en_s) begin
                    pch_r <= pc_inc_s[15:8];
                end else begin
                    pch_r <= pch_r;
                end
            end

            if (wr_idl_s) begin
                idl_r <= int_bus_s;
            end else if (load_dl) begin
                idl_r <= data_in;
            end else if (inc_dec_clr[IDC_CLEAR_IDL]) begin
                idl_r <= 8'h00;
            end else begin
                idl_r <= idl_r;
            end

            dbuff_r    <= wr_dbuff_s ? int_bus_s : dbuff_r;
            psr_r      <= wr_psr_s ? int_bus_s : psr_r;
            xfer_err_r <= xfer_err_r | conflict_s | vec_err_s | undef_err_s;
        end
    end

    assign reg_a     = a_r;
    assign reg_x     = x_r;
    assign reg_y     = y_r;
    assign reg_sp    = sp_r;
    assign reg_pcl   = pcl_r;
    assign reg_pch   = pch_r;
    assign reg_idl   = idl_r;
    assign reg_dbuff = dbuff_r;
    assign reg_psr   = psr_r;
    assign int_bus   = int_bus_s;
    assign vec_busy  = vec_busy_s;
    assign xfer_err  = xfer_err_r;

endmodule

// File: tb/tb_register_transfer_unit.sv
// Scoreboard bench for register_transfer_unit: directed scenarios then random
// control words, each cycle predicted by a behavioural model of the datapath.
module tb_register_transfer_unit;

    logic        fclk = 1'b0;
    logic        reset, rdy, adb_to_pc, load_dl;
    logic [3:0]  read, write;
    logic [9:0]  inc_dec_clr;
    logic [4:0]  vector_ops;
    logic [7:0]  alu_result, data_in, adl_in, adh_in;
    logic [7:0]  reg_a, reg_x, reg_y, reg_sp, reg_pcl, reg_pch;
    logic [7:0]  reg_idl, reg_dbuff, reg_psr, int_bus;
    logic        vec_busy, xfer_err;
    logic [15:0] vec_addr;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic       reset, rdy;
        logic [3:0] read, write;
        logic       adb;
        logic [9:0] idc;
        logic [4:0] vo;
        logic [7:0] alu, din;
        logic       load_dl;
        logic [7:0] adl, adh;
    } stim_t;

    typedef struct packed {
        logic [7:0]  a, x, y, sp, idl, dbuff, psr, temp;
        logic [15:0] pc, base;
        logic [1:0]  phase;
        logic        err;
    } model_t;

    model_t     m;
    model_t     mon_e;
    logic [7:0] mon_bus;
    model_t     state_q[$];
    logic [7:0] bus_q[$];

    register_transfer_unit dut (
        .fclk(fclk), .reset(reset), .rdy(rdy), .read(read), .write(write),
        .adb_to_pc(adb_to_pc), .inc_dec_clr(inc_dec_clr), .vector_ops(vector_ops),
        .alu_result(alu_result), .data_in(data_in), .load_dl(load_dl),
        .adl_in(adl_in), .adh_in(adh_in), .reg_a(reg_a), .reg_x(reg_x),
        .reg_y(reg_y), .reg_sp(reg_sp), .reg_pcl(reg_pcl), .reg_pch(reg_pch),
        .reg_idl(reg_idl), .reg_dbuff(reg_dbuff), .reg_psr(reg_psr),
        .int_bus(int_bus), .vec_busy(vec_busy), .vec_addr(vec_addr),
        .xfer_err(xfer_err)
    );

    always #5 fclk = ~fclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rdy   = 1'b1;
        s.read  = 4'hA;
        s.write = 4'hA;
        return s;
    endfunction

    function automatic model_t reset_model();
        model_t r;
        r     = '0;
        r.sp  = 8'hFF;
        r.psr = 8'h34;
        return r;
    endfunction

    function automatic logic [7:0] src_val(input model_t c, input stim_t s);
        case (s.read)
            4'h0:    return c.y;
            4'h1:    return c.x;
            4'h2:    return c.sp;
            4'h3:    return s.alu;
            4'h4:    return c.a;
            4'h5:    return c.pc[7:0];
            4'h6:    return c.pc[15:8];
            4'h7:    return c.idl;
            4'h8:    return c.dbuff;
            4'h9:    return c.psr;
            default: return 8'h00;
        endcase
    endfunction

    // Apply effects lowest priority first so that later, stronger updates overwrite them.
    function automatic model_t step(input model_t c, input stim_t s);
        model_t     n;
        logic       busy;
        logic [7:0] bus;
        n = c;
        if (s.reset) return reset_model();
        if (!s.rdy) return c;
        busy = (c.phase != 2'd0);
        bus  = src_val(c, s);
        n.a  = c.a  + 8'(s.idc[8]) - 8'(s.idc[7]);
        n.x  = c.x  + 8'(s.idc[6]) - 8'(s.idc[5]);
        n.y  = c.y  + 8'(s.idc[4]) - 8'(s.idc[3]);
        n.sp = c.sp + 8'(s.idc[2]) - 8'(s.idc[1]);
        if ((s.idc[8] && s.idc[7]) || (s.idc[6] && s.idc[5]) ||
            (s.idc[4] && s.idc[3]) || (s.idc[2] && s.idc[1])) n.err = 1'b1;
        if (s.idc[0]) n.idl = 8'h00;
        if (s.idc[9] && !busy) n.pc = c.pc + 16'd1;
        if (s.load_dl) n.idl = s.din;
        if (!busy) begin
            case (s.write)
                4'h0: n.y = bus;
                4'h1: n.x = bus;
                4'h2: n.sp = bus;
                4'h4: n.a = bus;
                4'h5: n.pc[7:0] = bus;
                4'h6: n.pc[15:8] = bus;
                4'h7: n.idl = bus;
                4'h8: n.dbuff = bus;
                4'h9: n.psr = bus;
                default: ;
            endcase
            if (s.adb) n.pc = {s.adh, s.adl};
        end
        if (s.vo[0]) n.sp = 8'hFF;
        if (c.phase == 2'd1) begin
            n.temp  = s.din;
            n.phase = 2'd2;
        end else if (c.phase == 2'd2) begin
            n.pc    = {s.din, c.temp};
            n.phase = 2'd0;
        end
        if (s.vo[4]) begin
            if (busy || $countones(s.vo[3:1]) != 1) begin
                n.err = 1'b1;
            end else begin
                n.phase = 2'd1;
                n.base  = s.vo[3] ? 16'hFFFC : (s.vo[2] ? 16'hFFFA : 16'hFFFE);
            end
        end
`ifdef RTU_UNDEF_TRAP_EN
        if (s.read > 4'hA || s.write > 4'hA) n.err = 1'b1;
`endif
        return n;
    endfunction

    // Drive one cycle, queue its predictions, and return 2 time units after the edge.
    task automatic issue(input stim_t s);
        reset = s.reset; rdy = s.rdy; read = s.read; write = s.write;
        adb_to_pc = s.adb; inc_dec_clr = s.idc; vector_ops = s.vo;
        alu_result = s.alu; data_in = s.din; load_dl = s.load_dl;
        adl_in = s.adl; adh_in = s.adh;
        bus_q.push_back(src_val(m, s));
        m = step(m, s);
        state_q.push_back(m);
        @(posedge fclk);
        #2;
    endtask

    always @(negedge fclk) begin
        if (bus_q.size() > 0) begin
            mon_bus = bus_q.pop_front();
            check("int_bus", int_bus, mon_bus);
        end
    end

    always @(posedge fclk) begin
        #1;
        if (state_q.size() > 0) begin
            mon_e = state_q.pop_front();
            check("reg_a", reg_a, mon_e.a);
            check("reg_x", reg_x, mon_e.x);
            check("reg_y", reg_y, mon_e.y);
            check("reg_sp", reg_sp, mon_e.sp);
            check("pc", {reg_pch, reg_pcl}, mon_e.pc);
            check("reg_idl", reg_idl, mon_e.idl);
            check("reg_dbuff", reg_dbuff, mon_e.dbuff);
            check("reg_psr", reg_psr, mon_e.psr);
            check("xfer_err", xfer_err, mon_e.err);
            check("vec_busy", vec_busy, mon_e.phase != 2'd0);
            if (mon_e.phase == 2'd1) check("vec_addr", vec_addr, mon_e.base);
            else if (mon_e.phase == 2'd2) check("vec_addr", vec_addr, mon_e.base + 16'd1);
        end
    end

    initial begin
        stim_t s;
        reset = 1'b1; rdy = 1'b1; read = 4'hA; write = 4'hA; adb_to_pc = 1'b0;
        inc_dec_clr = 10'd0; vector_ops = 5'd0; alu_result = 8'h00; data_in = 8'h00;
        load_dl = 1'b0; adl_in = 8'h00; adh_in = 8'h00;
        m = reset_model();
        @(posedge fclk);
        #2;

        s = idle(); s.reset = 1'b1; issue(s); issue(s);
        check("reset_sp", reg_sp, 8'hFF);
        check("reset_psr", reg_psr, 8'h34);

        s = idle(); s.read = 4'h3; s.write = 4'h1; s.alu = 8'h5A; issue(s);
        s = idle(); s.read = 4'h1; s.write = 4'h4; issue(s);
        check("x_to_a", reg_a, 8'h5A);

        s = idle(); s.adb = 1'b1; s.adh = 8'h00; s.adl = 8'hFF; issue(s);
        s = idle(); s.idc[9] = 1'b1; issue(s);
        check("pc_carry", {reg_pch, reg_pcl}, 16'h0100);
        s = idle(); s.adb = 1'b1; s.adh = 8'hFF; s.adl = 8'hFF; issue(s);
        s = idle(); s.idc[9] = 1'b1; issue(s);
        check("pc_wrap", {reg_pch, reg_pcl}, 16'h0000);
        s = idle(); s.read = 4'h3; s.write = 4'h2; s.alu = 8'h00; issue(s);
        s = idle(); s.idc[1] = 1'b1; issue(s);
        check("sp_wrap", reg_sp, 8'hFF);

        s = idle(); s.vo = 5'b11000; issue(s);
        check("res_addr_lo", vec_addr, 16'hFFFC);
        s = idle(); s.din = 8'h34; issue(s);
        check("res_addr_hi", vec_addr, 16'hFFFD);
        s = idle(); s.din = 8'h12; issue(s);
        check("res_pc", {reg_pch, reg_pcl}, 16'h1234);

        s = idle(); s.vo = 5'b10100; issue(s);
        s = idle(); s.rdy = 1'b0; s.din = 8'hEE; issue(s); issue(s);
        check("frozen_addr", vec_addr, 16'hFFFA);
        s = idle(); s.din = 8'hCD; issue(s);
        s = idle(); s.din = 8'hAB; issue(s);
        check("nmi_pc", {reg_pch, reg_pcl}, 16'hABCD);

        s = idle(); s.vo = 5'b10010; issue(s);
        s = idle(); s.din = 8'h77; issue(s);
        s = idle(); s.reset = 1'b1; issue(s);
        check("mid_fetch_reset_pc", {reg_pch, reg_pcl}, 16'h0000);
        check("mid_fetch_reset_busy", vec_busy, 1'b0);

        s = idle(); s.read = 4'h3; s.write = 4'h1; s.alu = 8'h10; issue(s);
        s = idle(); s.idc[6] = 1'b1; s.idc[5] = 1'b1; issue(s);
        check("conflict_x", reg_x, 8'h10);
        s = idle(); issue(s); issue(s);
        check("conflict_sticky", xfer_err, 1'b1);
        s = idle(); s.reset = 1'b1; issue(s);

        s = idle(); s.read = 4'h3; s.write = 4'h4; s.alu = 8'h33; issue(s);
        s = idle(); s.read = 4'h3; s.write = 4'hC; s.alu = 8'h99; issue(s);
        check("undef_write_a", reg_a, 8'h33);
`ifdef RTU_UNDEF_TRAP_EN
        check("undef_write_err", xfer_err, 1'b1);
`else
        check("undef_write_err", xfer_err, 1'b0);
`endif

        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.reset   = ($urandom_range(99) == 0);
            s.rdy     = ($urandom_range(7) != 0);
            s.read    = 4'($urandom_range(15));
            s.write   = 4'($urandom_range(15));
            s.adb     = ($urandom_range(7) == 0);
            s.load_dl = ($urandom_range(3) == 0);
            s.alu     = 8'($urandom);
            s.din     = 8'($urandom);
            s.adl     = 8'($urandom);
            s.adh     = 8'($urandom);
            for (int b = 0; b < 10; b++) s.idc[b] = ($urandom_range(9) == 0);
            s.vo[4]   = ($urandom_range(5) == 0);
            s.vo[3:1] = ($urandom_range(3) == 0) ? 3'($urandom_range(7))
                                                 : (3'b001 << $urandom_range(2));
            s.vo[0]   = ($urandom_range(15) == 0);
            issue(s);
        end

        check("queues_drained", state_q.size() + bus_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
